// File: rtl/detector_colision_if.sv
// Link between the obstacle generator and the collision detector: generator
// strobe/type/display one way, game result and bonus pulse back.
interface detector_colision_if;
    logic        clk_obstaculos;
    logic [4:0]  tipo_obs;
    logic [20:0] display_obs;
    logic [1:0]  W_or_L;
    logic        bono_tomado;

    modport master (
        output clk_obstaculos, tipo_obs, display_obs,
        input  W_or_L, bono_tomado
    );

    modport slave (
        input  clk_obstaculos, tipo_obs, display_obs,
        output W_or_L, bono_tomado
    );
endinterface

// File: rtl/detector_colision.sv
// Hero posture tracking plus collision / bonus decision when an obstacle
// reaches the hero digit; latches the game result until the game is left.
module detector_colision #(
    parameter int unsigned SALTO_TICKS = 3,
    parameter logic [2:0]  GAME        = 3'd3,
    parameter logic [2:0]  WL          = 3'd4,
    parameter logic [4:0]  TIPO_BONO   = 5'd16
) (
    input  logic                      clk,
    input  logic                      rst,
    detector_colision_if.slave        gen,
    input  logic [2:0]                presente,
    input  logic [1:0]                mundo,
    input  logic                      btn_saltar,
    input  logic                      btn_agachar,
    output logic [1:0]                heroe_estado
);
    typedef enum logic [1:0] {
        SUELO    = 2'b00,
        SALTO    = 2'b01,
        AGACHADO = 2'b10
    } heroe_t;

    localparam logic [1:0] K_NONE = 2'b00;
    localparam logic [1:0] K_LOW  = 2'b01;
    localparam logic [1:0] K_HIGH = 2'b10;
    localparam logic [1:0] K_BONO = 2'b11;
    localparam int         CW     = $clog2(SALTO_TICKS + 1);

    logic          prev_reg;
    logic          tick_d_reg;
    logic          saltar_prev_reg;
    logic [4:0]    tipo_prev_reg;
    logic [1:0]    kind_reg   [3];
    logic [1:0]    kind_shift [3];
    logic [1:0]    kind_in;
    logic [CW-1:0] cnt_reg;
    heroe_t        heroe_reg;
    logic [1:0]    wl_reg;
    logic          bono_reg;

    logic tick;
    logic en_juego;
    logic choque;
    logic gana;
    logic saltar_flanco;
    logic unused_display;

    // Only the entry digit matters; the other digits are display-only.
    assign unused_display = ^gen.display_obs[13:0];

    assign tick          = gen.clk_obstaculos & ~prev_reg;
    assign saltar_flanco = btn_saltar & ~saltar_prev_reg;
    assign en_juego      = (presente == GAME) || (presente == WL);

    always_comb begin
        kind_in = K_NONE;
        if (gen.tipo_obs == TIPO_BONO && tipo_prev_reg != TIPO_BONO)
            kind_in = K_BONO;
        else if (gen.display_obs[20:14] != 7'd0)
            kind_in = gen.tipo_obs[0] ? K_LOW : K_HIGH;
    end

    // Post-shift view of the pipeline: slot 0 is what sits at the hero digit.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_shift
            assign kind_shift[gi] = kind_reg[gi+1];
        end
    endgenerate
    assign kind_shift[2] = kind_in;

    // Evaluation uses the posture held before this cycle's FSM update.
    assign choque = en_juego && (wl_reg == 2'b00) && tick_d_reg &&
                    ((kind_shift[0] == K_LOW  && heroe_reg != SALTO) ||
                     (kind_shift[0] == K_HIGH && heroe_reg != AGACHADO));
    assign gana   = (presente == GAME) && (wl_reg == 2'b00) && (mundo == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg        <= 1'b0;
            tick_d_reg      <= 1'b0;
            saltar_prev_reg <= 1'b0;
            tipo_prev_reg   <= 5'd0;
            for (int i = 0; i < 3; i++) kind_reg[i] <= K_NONE;
            cnt_reg         <= '0;
            heroe_reg       <= SUELO;
            wl_reg          <= 2'b00;
            bono_reg        <= 1'b0;
        end else begin
            prev_reg        <= gen.clk_obstaculos;
            tick_d_reg      <= tick;
            saltar_prev_reg <= btn_saltar;
            bono_reg        <= 1'b0;
            if (!en_juego) begin
                tipo_prev_reg <= 5'd0;
                for (int i = 0; i < 3; i++) kind_reg[i] <= K_NONE;
                cnt_reg       <= '0;
                heroe_reg     <= SUELO;
                wl_reg        <= 2'b00;
            end else if (wl_reg == 2'b00) begin
                if (choque)
                    wl_reg <= 2'b01;
                else if (gana)
                    wl_reg <= 2'b10;

                if (tick_d_reg) begin
                    for (int i = 0; i < 3; i++) kind_reg[i] <= kind_shift[i];
                    tipo_prev_reg <= gen.tipo_obs;
                    bono_reg      <= (kind_shift[0] == K_BONO);
                end

                case (heroe_reg)
                    SUELO: begin
                        if (saltar_flanco) begin
                            heroe_reg <= SALTO;
                            cnt_reg   <= CW'(SALTO_TICKS);
                        end else if (btn_agachar) begin
                            heroe_reg <= AGACHADO;
                        end
                    end
                    SALTO: begin
                        if (tick_d_reg) begin
                            if (cnt_reg <= CW'(1)) begin
                                heroe_reg <= SUELO;
                                cnt_reg   <= '0;
                            end else begin
                                cnt_reg <= cnt_reg - CW'(1);
                            end
                        end
                    end
                    AGACHADO: begin
                        if (!btn_agachar) heroe_reg <= SUELO;
                    end
                    default: heroe_reg <= SUELO;
                endcase
            end
        end
    end

    assign gen.W_or_L      = wl_reg;
    assign gen.bono_tomado = bono_reg;
    assign heroe_estado    = heroe_reg;
endmodule

// File: tb/tb_detector_colision.sv
// Bench for detector_colision: directed obstacle scenarios from a table,
// hand-written freeze/win/leave sequences, and a randomized run against a model.
module tb_detector_colision;
    localparam int SALTO = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] presente;
    logic [1:0] mundo;
    logic       btn_saltar;
    logic       btn_agachar;
    logic [1:0] heroe_estado;

    detector_colision_if bus ();

    detector_colision #(.SALTO_TICKS(SALTO)) dut (
        .clk          (clk),
        .rst          (rst),
        .gen          (bus),
        .presente     (presente),
        .mundo        (mundo),
        .btn_saltar   (btn_saltar),
        .btn_agachar  (btn_agachar),
        .heroe_estado (heroe_estado)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int bonos    = 0;
    bit chk_en   = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // Reference model: obstacles travel through a 3-entry queue (front = hero
    // digit); posture is a number with a remaining-jump tick count.
    int q[$] = '{0, 0, 0};
    int m_prev = 0, m_tickd = 0, m_sprev = 0, m_tprev = 0;
    int m_wl = 0, m_bono = 0, m_post = 0, m_jump = 0;

    always @(posedge clk) begin
        int newk, h, lost, nbono, ingame, new_tickd;
        new_tickd = (bus.clk_obstaculos && !m_prev) ? 1 : 0;
        nbono = 0;
        if (rst) begin
            q = '{0, 0, 0};
            m_prev = 0; m_tickd = 0; m_sprev = 0; m_tprev = 0;
            m_wl = 0; m_bono = 0; m_post = 0; m_jump = 0;
        end else begin
            ingame = (presente == 3'd3 || presente == 3'd4) ? 1 : 0;
            if (!ingame) begin
                q = '{0, 0, 0};
                m_tprev = 0; m_wl = 0; m_post = 0; m_jump = 0;
            end else if (m_wl == 0) begin
                lost = 0;
                if (m_tickd) begin
                    if (bus.tipo_obs == 16 && m_tprev != 16) newk = 3;
                    else if (bus.display_obs[20:14] != 0) newk = bus.tipo_obs[0] ? 1 : 2;
                    else newk = 0;
                    q.push_back(newk);
                    void'(q.pop_front());
                    h = q[0];
                    if (h == 1 && m_post != 1) lost = 1;
                    if (h == 2 && m_post != 2) lost = 1;
                    if (h == 3) nbono = 1;
                    m_tprev = bus.tipo_obs;
                end
                if (m_post == 0) begin
                    if (btn_saltar && !m_sprev) begin m_post = 1; m_jump = SALTO; end
                    else if (btn_agachar) m_post = 2;
                end else if (m_post == 1) begin
                    if (m_tickd) begin
                        m_jump = m_jump - 1;
                        if (m_jump <= 0) begin m_post = 0; m_jump = 0; end
                    end
                end else begin
                    if (!btn_agachar) m_post = 0;
                end
                if (lost) m_wl = 1;
                else if (presente == 3'd3 && mundo == 2'd3) m_wl = 2;
            end
            m_prev  = bus.clk_obstaculos;
            m_tickd = new_tickd;
            m_sprev = btn_saltar;
            m_bono  = nbono;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_wl", bus.W_or_L, m_wl);
            chk("model_bono", bus.bono_tomado, m_bono);
            chk("model_heroe", heroe_estado, m_post);
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.bono_tomado) bonos++;
        end
    endtask

    task automatic tick();
        bus.clk_obstaculos = 1'b1;
        cyc(4);
        bus.clk_obstaculos = 1'b0;
        cyc(4);
    endtask

    typedef struct {
        int         tipo;
        bit         jump;
        bit         duck;
        logic [1:0] exp_wl;
        logic [1:0] exp_heroe;
        int         exp_bonos;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{5,  1'b0, 1'b0, 2'b01, 2'b00, 0};
        vecs[1] = '{5,  1'b1, 1'b0, 2'b00, 2'b00, 0};
        vecs[2] = '{6,  1'b0, 1'b1, 2'b00, 2'b10, 0};
        vecs[3] = '{6,  1'b0, 1'b0, 2'b01, 2'b00, 0};
        vecs[4] = '{6,  1'b1, 1'b0, 2'b01, 2'b01, 0};
        vecs[5] = '{5,  1'b0, 1'b1, 2'b01, 2'b10, 0};
        vecs[6] = '{16, 1'b0, 1'b0, 2'b00, 2'b00, 1};

        rst = 1'b1; presente = 3'd3; mundo = 2'd0;
        btn_saltar = 1'b0; btn_agachar = 1'b0;
        bus.clk_obstaculos = 1'b0; bus.tipo_obs = 5'd0; bus.display_obs = 21'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.clk_obstaculos = ~bus.clk_obstaculos;
        end
        rst = 1'b0;
        bus.clk_obstaculos = 1'b0;
        cyc(1);
        chk("reset_wl", bus.W_or_L, 0);
        chk("reset_heroe", heroe_estado, 0);
        chk("reset_bono", bus.bono_tomado, 0);
        chk_en = 1;

        for (int v = 0; v < 7; v++) begin
            btn_saltar = 1'b0; btn_agachar = 1'b0; mundo = 2'd0;
            presente = 3'd0; bus.display_obs = 21'd0; bus.tipo_obs = 5'd0;
            cyc(2);
            presente = 3'd3;
            bonos = 0;
            bus.tipo_obs = 5'(vecs[v].tipo);
            bus.display_obs = {7'h3F, 14'd0};
            tick();
            bus.display_obs = 21'd0;
            if (vecs[v].duck) btn_agachar = 1'b1;
            tick();
            if (vecs[v].jump) begin
                btn_saltar = 1'b1;
                cyc(1);
                btn_saltar = 1'b0;
            end
            for (int t = 0; t < 11; t++) tick();
            chk($sformatf("vec%0d_wl", v), bus.W_or_L, vecs[v].exp_wl);
            chk($sformatf("vec%0d_heroe", v), heroe_estado, vecs[v].exp_heroe);
            chk($sformatf("vec%0d_bonos", v), bonos, vecs[v].exp_bonos);
        end

        mundo = 2'd3;
        cyc(1);
        chk("win_wl", bus.W_or_L, 2);
        cyc(3);
        chk("win_hold", bus.W_or_L, 2);
        presente = 3'd0;
        cyc(1);
        chk("leave_after_win", bus.W_or_L, 0);

        // Loss while a second obstacle is still in flight; leaving must drop it.
        mundo = 2'd0; presente = 3'd3; bus.tipo_obs = 5'd5;
        bus.display_obs = {7'h3F, 14'd0};
        tick();
        tick();
        bus.display_obs = 21'd0;
        tick();
        chk("pending_loss", bus.W_or_L, 1);
        presente = 3'd0;
        cyc(1);
        chk("leave_after_loss", bus.W_or_L, 0);
        cyc(1);
        presente = 3'd3;
        bonos = 0;
        for (int t = 0; t < 4; t++) tick();
        chk("return_no_loss", bus.W_or_L, 0);
        chk("return_no_bono", bonos, 0);

        begin
            int half = 3, cnt = 0;
            for (int c = 0; c < 4000; c++) begin
                @(negedge clk);
                rst = ($urandom_range(0, 499) == 0);
                cnt++;
                if (cnt >= half) begin
                    cnt = 0;
                    half = $urandom_range(2, 6);
                    bus.clk_obstaculos = ~bus.clk_obstaculos;
                    if (bus.clk_obstaculos) begin
                        case ($urandom_range(0, 3))
                            0: bus.tipo_obs = 5'd5;
                            1: bus.tipo_obs = 5'd6;
                            2: bus.tipo_obs = 5'd16;
                            default: bus.tipo_obs = 5'($urandom_range(0, 31));
                        endcase
                        bus.display_obs = ($urandom_range(0, 1) == 1) ?
                                          {7'($urandom_range(1, 127)), 14'($urandom)} : 21'd0;
                    end
                end
                if ($urandom_range(0, 19) == 0) btn_saltar = ~btn_saltar;
                if ($urandom_range(0, 24) == 0) btn_agachar = ~btn_agachar;
                if ($urandom_range(0, 149) == 0) begin
                    case ($urandom_range(0, 5))
                        0: presente = 3'd0;
                        1: presente = 3'd4;
                        2: presente = 3'd1;
                        default: presente = 3'd3;
                    endcase
                end
                if ($urandom_range(0, 299) == 0) mundo = 2'($urandom_range(0, 3));
            end
        end
        rst = 1'b0;
        cyc(2);
        chk_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
